obs_field: RTL and testbench

- Parametrised multi-obstacle engine for the VGA shooter.
- Holds N_OBS independent falling obstacles and spawns them at LFSR-random x positions on a fixed frame cadence.
- Moves every obstacle once per frame at a level-scaled speed, and detects shot-vs-obstacle hits and floor misses.
- Sits between the sync/pixel counter and the game FSM/score logic. Drives obs_on into the colour mux, and hit/miss pulses into the score/life counters.

---
 rtl/obs_field_if.sv | 36 +++
 rtl/obs_field.sv | 184 ++++++++++++++++++
 tb/tb_obs_field.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obs_field_if.sv
// obs_field_if -- bundle between the obstacle engine and its surroundings.
//   Inputs to the engine: frame_tick, run, clr, level, pixel x/y and the
//   shot box (shot_valid, shot_x_l/r, shot_y_t/b, inclusive bounds).
//   Outputs from the engine: obs_on (colour mux), hit/miss pulses,
//   hit_idx (slot of last hit) and active_cnt (valid slot count).
//   master: the game side driving the engine; slave: the engine itself.
interface obs_field_if;
  logic       frame_tick;
  logic       run;
  logic       clr;
  logic [2:0] level;
  logic [9:0] x;
  logic [9:0] y;
  logic       shot_valid;
  logic [9:0] shot_x_l;
  logic [9:0] shot_x_r;
  logic [9:0] shot_y_t;
  logic [9:0] shot_y_b;
  logic       obs_on;
  logic       hit;
  logic       miss;
  logic [2:0] hit_idx;
  logic [3:0] active_cnt;

  modport master (
    output frame_tick, run, clr, level, x, y,
           shot_valid, shot_x_l, shot_x_r, shot_y_t, shot_y_b,
    input  obs_on, hit, miss, hit_idx, active_cnt
  );

  modport slave (
    input  frame_tick, run, clr, level, x, y,
           shot_valid, shot_x_l, shot_x_r, shot_y_t, shot_y_b,
    output obs_on, hit, miss, hit_idx, active_cnt
  );
endinterface

// File: rtl/obs_field.sv
// obs_field -- multi-obstacle engine for the VGA shooter.
//   Holds N_OBS falling square obstacles, spawns them at pseudo-random x
//   every SPAWN_PERIOD processed frames, moves them by OBS_V+level per
//   frame, and reports shot hits and floor misses.
// Ports:
//   clk  pixel clock
//   rst  asynchronous, active-high reset
//   bus  obs_field_if.slave: frame_tick/run/clr/level, pixel x/y, shot box
//        in; obs_on (combinational), hit/miss (pulses during the processed
//        frame_tick clk), hit_idx, active_cnt (registered) out.
module obs_field #(
  parameter int          N_OBS        = 4,
  parameter int          MAX_X        = 640,
  parameter int          MAX_Y        = 480,
  parameter int          OBS_SIZE     = 20,
  parameter int          OBS_V        = 2,
  parameter int          SPAWN_PERIOD = 30,
  parameter int          TOP_Y        = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic         clk,
  input logic         rst,
  obs_field_if.slave  bus
);

  localparam int          CNT_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [10:0] Y_LIMIT = 11'(MAX_Y - OBS_SIZE);
  localparam logic [9:0]  X_SPAN  = 10'(MAX_X - OBS_SIZE);
  localparam logic [10:0] EDGE    = 11'(OBS_SIZE - 1);

  logic [N_OBS-1:0] valid_q, valid_d;
  logic [9:0]       x_q [N_OBS];
  logic [9:0]       x_d [N_OBS];
  logic [9:0]       y_q [N_OBS];
  logic [9:0]       y_d [N_OBS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       hit_idx_q, hit_idx_d;
  logic [3:0]       active_q, active_d;

  logic [10:0]      x_r   [N_OBS];
  logic [10:0]      y_b   [N_OBS];
  logic [10:0]      y_sum [N_OBS];
  logic [N_OBS-1:0] overlap;
  logic [N_OBS-1:0] pix_in;
  logic [10:0]      vel;
  logic [9:0]       spawn_x;
  logic             frame_go;
  logic             hit_any;
  logic             free_found;
  int unsigned      hit_sel;
  int unsigned      free_sel;
  logic             hit_c;
  logic             miss_c;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form); free-running.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Fold 10-bit random value into the legal x range with one subtraction.
  assign spawn_x = (lfsr_q[9:0] > X_SPAN) ? (lfsr_q[9:0] - X_SPAN) : lfsr_q[9:0];

  assign vel      = 11'(OBS_V) + {8'd0, bus.level};
  assign frame_go = bus.frame_tick && bus.run && !bus.clr;

  // Per-slot geometry: edges, shot overlap, pixel coverage, next y.
  always_comb begin
    for (int unsigned i = 0; i < N_OBS; i++) begin
      x_r[i]     = {1'b0, x_q[i]} + EDGE;
      y_b[i]     = {1'b0, y_q[i]} + EDGE;
      y_sum[i]   = {1'b0, y_q[i]} + vel;
      overlap[i] = valid_q[i] && bus.shot_valid &&
                   ({1'b0, bus.shot_x_r} >= {1'b0, x_q[i]}) &&
                   ({1'b0, bus.shot_x_l} <= x_r[i]) &&
                   ({1'b0, bus.shot_y_b} >= {1'b0, y_q[i]}) &&
                   ({1'b0, bus.shot_y_t} <= y_b[i]);
      pix_in[i]  = valid_q[i] &&
                   ({1'b0, bus.x} >= {1'b0, x_q[i]}) && ({1'b0, bus.x} <= x_r[i]) &&
                   ({1'b0, bus.y} >= {1'b0, y_q[i]}) && ({1'b0, bus.y} <= y_b[i]);
    end
  end

  // Lowest-index overlapping slot and lowest-index slot free before the frame.
  always_comb begin
    hit_any    = 1'b0;
    hit_sel    = 0;
    free_found = 1'b0;
    free_sel   = 0;
    for (int unsigned i = 0; i < N_OBS; i++) begin
      if (overlap[i] && !hit_any) begin
        hit_any = 1'b1;
        hit_sel = i;
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_sel   = i;
      end
    end
  end

  // Frame processing: hit > miss > move per slot, then spawn into a slot
  // that was already free, so a slot cleared this frame is never refilled
  // in the same frame.
  always_comb begin
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    hit_idx_d = hit_idx_q;
    miss_c    = 1'b0;
    if (bus.clr) begin
      valid_d = '0;
    end else if (frame_go) begin
      for (int unsigned i = 0; i < N_OBS; i++) begin
        if (hit_any && (i == hit_sel)) begin
          valid_d[i] = 1'b0;
        end else if (valid_q[i]) begin
          if (y_sum[i] > Y_LIMIT) begin
            valid_d[i] = 1'b0;
            miss_c     = 1'b1;
          end else begin
            y_d[i] = y_sum[i][9:0];
          end
        end
      end
      if (hit_any) begin
        hit_idx_d = 3'(hit_sel);
      end
      if (cnt_q == CNT_W'(SPAWN_PERIOD - 1)) begin
        cnt_d = '0;
        for (int unsigned i = 0; i < N_OBS; i++) begin
          if (free_found && (i == free_sel)) begin
            valid_d[i] = 1'b1;
            x_d[i]     = spawn_x;
            y_d[i]     = 10'(TOP_Y);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_c = frame_go && hit_any;

  always_comb begin
    active_d = '0;
    for (int unsigned i = 0; i < N_OBS; i++) begin
      active_d = active_d + 4'(valid_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      for (int unsigned i = 0; i < N_OBS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      hit_idx_q <= '0;
      active_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      for (int unsigned i = 0; i < N_OBS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      hit_idx_q <= hit_idx_d;
      active_q  <= active_d;
    end
  end

  assign bus.obs_on     = |pix_in;
  assign bus.hit        = hit_c;
  assign bus.miss       = miss_c;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.active_cnt = active_q;

endmodule

// File: tb/tb_obs_field.sv
module tb_obs_field;
  localparam int          N_OBS        = 4;
  localparam int          MAX_X        = 640;
  localparam int          MAX_Y        = 480;
  localparam int          OBS_SIZE     = 20;
  localparam int          OBS_V        = 2;
  localparam int          SPAWN_PERIOD = 30;
  localparam int          TOP_Y        = 16;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obs_field_if bus ();

  obs_field #(
    .N_OBS(N_OBS), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .OBS_SIZE(OBS_SIZE),
    .OBS_V(OBS_V), .SPAWN_PERIOD(SPAWN_PERIOD), .TOP_Y(TOP_Y), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_hit  = 0;
  int n_miss = 0;

  // Reference model: obstacle list as plain integers.
  bit          m_valid [N_OBS];
  int          m_x     [N_OBS];
  int          m_y     [N_OBS];
  int          m_frames;
  logic [15:0] m_lfsr;
  int          m_hit_idx;
  int          m_active;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OBS; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_frames = 0; m_lfsr = SEED; m_hit_idx = 0; m_active = 0;
  endtask

  function automatic bit inside_box(input int px, input int py, input int bx, input int by);
    return px >= bx && px <= bx + OBS_SIZE - 1 && py >= by && py <= by + OBS_SIZE - 1;
  endfunction

  function automatic int first_hit();
    if (!bus.shot_valid) return -1;
    for (int i = 0; i < N_OBS; i++)
      if (m_valid[i] && int'(bus.shot_x_r) >= m_x[i] && int'(bus.shot_x_l) <= m_x[i] + OBS_SIZE - 1 &&
          int'(bus.shot_y_b) >= m_y[i] && int'(bus.shot_y_t) <= m_y[i] + OBS_SIZE - 1)
        return i;
    return -1;
  endfunction

  function automatic bit processing();
    return bus.frame_tick && bus.run && !bus.clr;
  endfunction

  function automatic int speed();
    return OBS_V + int'(bus.level);
  endfunction

  function automatic bit exp_miss();
    int h = first_hit();
    if (!processing()) return 0;
    for (int i = 0; i < N_OBS; i++)
      if (m_valid[i] && i != h && m_y[i] + speed() > MAX_Y - OBS_SIZE) return 1;
    return 0;
  endfunction

  function automatic bit exp_obs_on();
    for (int i = 0; i < N_OBS; i++)
      if (m_valid[i] && inside_box(int'(bus.x), int'(bus.y), m_x[i], m_y[i])) return 1;
    return 0;
  endfunction

  // Apply one clock edge of game rules to the model.
  task automatic model_edge();
    int  cnt = 0;
    int  h;
    int  free_slot = -1;
    int  r;
    for (int i = 0; i < N_OBS; i++) if (m_valid[i]) cnt++;
    if (bus.clr) begin
      for (int i = 0; i < N_OBS; i++) m_valid[i] = 0;
    end else if (processing()) begin
      h = first_hit();
      for (int i = 0; i < N_OBS; i++) if (!m_valid[i] && free_slot < 0) free_slot = i;
      for (int i = 0; i < N_OBS; i++) begin
        if (!m_valid[i]) continue;
        if (i == h) m_valid[i] = 0;
        else if (m_y[i] + speed() > MAX_Y - OBS_SIZE) m_valid[i] = 0;
        else m_y[i] = m_y[i] + speed();
      end
      if (h >= 0) m_hit_idx = h;
      m_frames++;
      if (m_frames == SPAWN_PERIOD) begin
        m_frames = 0;
        if (free_slot >= 0) begin
          r = int'(m_lfsr[9:0]);
          if (r > MAX_X - OBS_SIZE) r = r - (MAX_X - OBS_SIZE);
          m_valid[free_slot] = 1; m_x[free_slot] = r; m_y[free_slot] = TOP_Y;
        end
      end
    end
    m_active = cnt;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_model();
    check("obs_on", int'(bus.obs_on), int'(exp_obs_on()));
    check("hit", int'(bus.hit), int'(processing() && first_hit() >= 0));
    check("miss", int'(bus.miss), int'(exp_miss()));
    check("hit_idx", int'(bus.hit_idx), m_hit_idx);
    check("active_cnt", int'(bus.active_cnt), m_active);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    if (bus.hit) n_hit++;
    if (bus.miss) n_miss++;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic shot_box(input bit en, input int xl, input int xr, input int yt, input int yb);
    bus.shot_valid = en;
    bus.shot_x_l = 10'(xl); bus.shot_x_r = 10'(xr);
    bus.shot_y_t = 10'(yt); bus.shot_y_b = 10'(yb);
  endtask

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  function automatic int pick_offset();
    case ($urandom_range(0, 4))
      0: return -1;
      1: return 0;
      2: return OBS_SIZE - 1;
      3: return OBS_SIZE;
      default: return int'($urandom_range(0, OBS_SIZE - 1));
    endcase
  endfunction

  task automatic rand_inputs();
    int k;
    int xl, yt;
    bus.frame_tick = 1'($urandom_range(0, 1));
    bus.run        = ($urandom_range(0, 9) != 0);
    bus.clr        = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 19) == 0) bus.level = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) begin
      k  = int'($urandom_range(0, N_OBS - 1));
      xl = clamp10(m_x[k] + int'($urandom_range(0, 50)) - 30);
      yt = clamp10(m_y[k] + int'($urandom_range(0, 50)) - 30);
      shot_box($urandom_range(0, 3) != 0, xl, clamp10(xl + int'($urandom_range(0, 10))),
               yt, clamp10(yt + int'($urandom_range(0, 10))));
    end else begin
      shot_box(0, 0, 1023, 0, 1023);
    end
    if ($urandom_range(0, 3) == 0) begin
      bus.x = 10'($urandom_range(0, 639));
      bus.y = 10'($urandom_range(0, 479));
    end else begin
      k = int'($urandom_range(0, N_OBS - 1));
      bus.x = 10'(clamp10(m_x[k] + pick_offset()));
      bus.y = 10'(clamp10(m_y[k] + pick_offset()));
    end
  endtask

  typedef struct {
    int reps;
    bit ft;
    bit run;
    bit clr;
    bit shot_all;
    int exp_cnt;
    bit exp_hit;
    bit exp_miss;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   h0;

    // reps, frame_tick, run, clr, full-screen shot, active_cnt, hit, miss
    tbl.push_back('{1,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{29, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1,  1, 1, 0, 0, 0, 0, 0});  // 30th frame: spawn into slot 0
    tbl.push_back('{1,  0, 1, 0, 0, 0, 0, 0});  // active_cnt lags one clk
    tbl.push_back('{1,  0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,  1, 0, 0, 1, 1, 0, 0});  // frozen: no pulse
    tbl.push_back('{50, 1, 0, 0, 0, 1, 0, 0});  // frozen 50 frames
    tbl.push_back('{1,  1, 1, 0, 1, 1, 1, 0});  // hit slot 0, counter 0->1
    tbl.push_back('{1,  0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{28, 1, 1, 0, 0, 0, 0, 0});  // counter 1->29
    tbl.push_back('{1,  1, 1, 0, 0, 0, 0, 0});  // spawn
    tbl.push_back('{1,  0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1,  0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,  1, 1, 1, 1, 1, 0, 0});  // clr wins over frame, no pulse
    tbl.push_back('{1,  1, 1, 0, 1, 1, 0, 0});  // slots empty now
    tbl.push_back('{1,  0, 1, 0, 0, 0, 0, 0});

    rst = 1'b1;
    bus.frame_tick = 0; bus.run = 0; bus.clr = 0; bus.level = 0;
    bus.x = 0; bus.y = 0;
    shot_box(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check("rst_obs_on", int'(bus.obs_on), 0);
    check("rst_hit", int'(bus.hit), 0);
    check("rst_miss", int'(bus.miss), 0);
    check("rst_hit_idx", int'(bus.hit_idx), 0);
    check("rst_active", int'(bus.active_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      for (int r = 0; r < tbl[k].reps; r++) begin
        bus.frame_tick = tbl[k].ft;
        bus.run        = tbl[k].run;
        bus.clr        = tbl[k].clr;
        if (tbl[k].shot_all) shot_box(1, 0, 1023, 0, 1023);
        else shot_box(0, 0, 0, 0, 0);
        @(negedge clk);
        check($sformatf("tbl%0d_active", k), int'(bus.active_cnt), tbl[k].exp_cnt);
        check($sformatf("tbl%0d_hit", k), int'(bus.hit), int'(tbl[k].exp_hit));
        check($sformatf("tbl%0d_miss", k), int'(bus.miss), int'(tbl[k].exp_miss));
        check_model();
        @(posedge clk);
        model_edge();
        #1;
      end
    end

    // Fill every slot at base speed, then let one more spawn be dropped.
    bus.clr = 0; bus.run = 1; bus.frame_tick = 1; bus.level = 0;
    shot_box(0, 0, 0, 0, 0);
    repeat (150) step();
    bus.frame_tick = 0;
    step();
    check("full_active", int'(bus.active_cnt), N_OBS);
    bus.frame_tick = 1;
    repeat (30) step();
    bus.frame_tick = 0;
    step();
    check("drop_active", int'(bus.active_cnt), N_OBS);

    // Full-screen shot: one slot per frame, lowest index first.
    n_hit = 0;
    h0 = 0;
    bus.frame_tick = 1;
    shot_box(1, 0, 1023, 0, 1023);
    step();
    check("multi_first_idx", int'(bus.hit_idx), 0);
    repeat (3) step();
    bus.frame_tick = 0;
    step();
    check("multi_hit_count", n_hit, 4);
    check("multi_last_idx", int'(bus.hit_idx), 3);

    // Fast fall to the floor.
    n_miss = 0;
    shot_box(0, 0, 0, 0, 0);
    bus.level = 7; bus.frame_tick = 1;
    repeat (120) step();
    check("miss_seen", int'(n_miss > 0), 1);

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of a clk.
    bus.clr = 0; bus.run = 1; bus.frame_tick = 0;
    for (int i = N_OBS - 1; i >= 0; i--)
      if (m_valid[i]) begin bus.x = 10'(m_x[i]); bus.y = 10'(m_y[i]); end
    shot_box(1, 0, 1023, 0, 1023);
    bus.frame_tick = 1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_obs_on", int'(bus.obs_on), 0);
    check("arst_hit", int'(bus.hit), 0);
    check("arst_miss", int'(bus.miss), 0);
    check("arst_hit_idx", int'(bus.hit_idx), 0);
    check("arst_active", int'(bus.active_cnt), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
